// File: rtl/write_back_arb.sv
// Write-back arbiter: round-robin merge of NCH result channels into one
// registered register-file write port, with x0 suppression and a retire counter.
module write_back_arb #(
    parameter int XLEN  = 32,
    parameter int XADDR = 5,
    parameter int NCH   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NCH-1:0]        i_valid,
    input  logic [NCH*XADDR-1:0]  i_rd_addr,
    input  logic [NCH-1:0]        i_rd_write,
    input  logic [NCH*XLEN-1:0]   i_rd_data,
    input  logic                  i_flush,
    output logic [NCH-1:0]        o_ready,
    output logic [XADDR-1:0]      or_rd_addr,
    output logic                  or_rd_write,
    output logic [XLEN-1:0]       or_rd_data,
    output logic                  or_valid,
    output logic [63:0]           or_instret,
    output logic                  or_stall
);

    // A one-bit pointer is kept even for NCH=1; it simply never leaves 0.
    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             retire;
    logic             stall_next;
    logic [XADDR-1:0] sel_addr;
    logic [XLEN-1:0]  sel_data;
    logic             sel_write;

    // Search from ptr upward, wrapping, and take the first valid channel.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_any && i_valid[(int'(ptr) + i) % NCH]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'((int'(ptr) + i) % NCH);
            end
        end
    end

    always_comb begin
        o_ready = '0;
        if (i_flush) begin
            o_ready = '1;
        end else if (grant_any) begin
            o_ready[grant_idx] = 1'b1;
        end
    end

    assign retire     = grant_any && !i_flush;
    assign stall_next = ($countones(i_valid) > 1) && !i_flush;
    assign ptr_next   = (grant_idx == PTR_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;

    assign sel_addr  = i_rd_addr[grant_idx*XADDR +: XADDR];
    assign sel_data  = i_rd_data[grant_idx*XLEN +: XLEN];
    assign sel_write = i_rd_write[grant_idx] && (sel_addr != '0);

    // Output register: payload holds when nothing retires, only the
    // qualifiers drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr         <= '0;
            or_rd_addr  <= '0;
            or_rd_data  <= '0;
            or_rd_write <= 1'b0;
            or_valid    <= 1'b0;
            or_instret  <= '0;
            or_stall    <= 1'b0;
        end else begin
            or_stall <= stall_next;
            if (retire) begin
                ptr         <= ptr_next;
                or_rd_addr  <= sel_addr;
                or_rd_data  <= sel_data;
                or_rd_write <= sel_write;
                or_valid    <= 1'b1;
                or_instret  <= or_instret + 64'd1;
            end else begin
                or_rd_write <= 1'b0;
                or_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_write_back_arb.sv
// Directed bench for write_back_arb: a two-channel and a three-channel instance.
module tb_write_back_arb;

    logic clk;
    logic rst_n;

    logic [1:0]  v2;
    logic [9:0]  a2;
    logic [1:0]  w2;
    logic [63:0] d2;
    logic        f2;
    logic [1:0]  ready2;
    logic [4:0]  ra2;
    logic        rw2;
    logic [31:0] rd2;
    logic        ov2;
    logic [63:0] ir2;
    logic        st2;

    logic [2:0]  v3;
    logic [14:0] a3;
    logic [2:0]  w3;
    logic [95:0] d3;
    logic        f3;
    logic [2:0]  ready3;
    logic [4:0]  ra3;
    logic        rw3;
    logic [31:0] rd3;
    logic        ov3;
    logic [63:0] ir3;
    logic        st3;

    int tests;
    int fails;

    write_back_arb #(.XLEN(32), .XADDR(5), .NCH(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .i_rd_addr(a2),
        .i_rd_write(w2), .i_rd_data(d2), .i_flush(f2), .o_ready(ready2),
        .or_rd_addr(ra2), .or_rd_write(rw2), .or_rd_data(rd2),
        .or_valid(ov2), .or_instret(ir2), .or_stall(st2)
    );

    write_back_arb #(.XLEN(32), .XADDR(5), .NCH(3)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_rd_addr(a3),
        .i_rd_write(w3), .i_rd_data(d3), .i_flush(f3), .o_ready(ready3),
        .or_rd_addr(ra3), .or_rd_write(rw3), .or_rd_data(rd3),
        .or_valid(ov3), .or_instret(ir3), .or_stall(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        v2 = '0; a2 = '0; w2 = '0; d2 = '0; f2 = 1'b0;
        v3 = '0; a3 = '0; w3 = '0; d3 = '0; f3 = 1'b0;
        #2;
        check("reset_valid", 64'(ov2), 64'd0);
        check("reset_instret", ir2, 64'd0);
        check("reset_ready", 64'(ready2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write on channel 0
        v2 = 2'b01; a2[4:0] = 5'd3; w2 = 2'b01; d2[31:0] = 32'hDEADBEEF;
        #1 check("single_ready", 64'(ready2), 64'd1);
        step();
        check("single_addr", 64'(ra2), 64'd3);
        check("single_data", 64'(rd2), 64'hDEADBEEF);
        check("single_write", 64'(rw2), 64'd1);
        check("single_valid", 64'(ov2), 64'd1);
        check("single_instret", ir2, 64'd1);
        check("single_stall", 64'(st2), 64'd0);

        // Write to x0 on channel 1 retires but does not write
        v2 = 2'b10; a2[9:5] = 5'd0; w2 = 2'b10; d2[63:32] = 32'h1234;
        #1 check("x0_ready", 64'(ready2), 64'd2);
        step();
        check("x0_write", 64'(rw2), 64'd0);
        check("x0_valid", 64'(ov2), 64'd1);
        check("x0_instret", ir2, 64'd2);
        check("x0_data", 64'(rd2), 64'h1234);

        // Idle cycle holds payload
        v2 = 2'b00;
        step();
        check("idle_valid", 64'(ov2), 64'd0);
        check("idle_write", 64'(rw2), 64'd0);
        check("idle_data_hold", 64'(rd2), 64'h1234);
        check("idle_instret", ir2, 64'd2);

        // Flush with both channels valid
        v2 = 2'b11; w2 = 2'b11; a2[4:0] = 5'd7; a2[9:5] = 5'd9; f2 = 1'b1;
        d2[31:0] = 32'hAAAA0000; d2[63:32] = 32'hBBBB0000;
        #1 check("flush_ready", 64'(ready2), 64'd3);
        step();
        check("flush_valid", 64'(ov2), 64'd0);
        check("flush_write", 64'(rw2), 64'd0);
        check("flush_instret", ir2, 64'd2);
        check("flush_stall", 64'(st2), 64'd0);
        check("flush_data_hold", 64'(rd2), 64'h1234);

        // Pointer is still at 0 after the flush; contention sets stall
        f2 = 1'b0;
        #1 check("postflush_ready", 64'(ready2), 64'd1);
        step();
        check("contend_addr", 64'(ra2), 64'd7);
        check("contend_instret", ir2, 64'd3);
        check("contend_stall", 64'(st2), 64'd1);
        v2 = 2'b10;
        #1 check("held_ready", 64'(ready2), 64'd2);
        step();
        check("held_addr", 64'(ra2), 64'd9);
        check("held_data", 64'(rd2), 64'hBBBB0000);
        check("held_stall", 64'(st2), 64'd0);
        v2 = 2'b01;
        step();
        check("pre_reset_instret", ir2, 64'd5);

        // Asynchronous reset mid-stream; pointer was 1, must return to 0
        v2 = 2'b11;
        rst_n = 1'b0;
        #1;
        check("areset_instret", ir2, 64'd0);
        check("areset_valid", 64'(ov2), 64'd0);
        check("areset_addr", 64'(ra2), 64'd0);
        check("areset_data", 64'(rd2), 64'd0);
        check("areset_stall", 64'(st2), 64'd0);
        check("areset_ptr", 64'(ready2), 64'd1);
        #2 rst_n = 1'b1;
        step();
        check("after_reset_addr", 64'(ra2), 64'd7);
        check("after_reset_instret", ir2, 64'd1);
        v2 = 2'b00;
        step();

        // Three-channel round robin, all valid for six cycles
        v3 = 3'b111; w3 = 3'b111;
        a3[4:0] = 5'd1; a3[9:5] = 5'd2; a3[14:10] = 5'd3;
        d3[31:0] = 32'h100; d3[63:32] = 32'h200; d3[95:64] = 32'h300;
        for (int c = 0; c < 6; c++) begin
            #1 check($sformatf("rr_ready_%0d", c), 64'(ready3), 64'(3'b001 << (c % 3)));
            step();
            check($sformatf("rr_addr_%0d", c), 64'(ra3), 64'((c % 3) + 1));
            check($sformatf("rr_stall_%0d", c), 64'(st3), 64'd1);
        end
        check("rr_instret", ir3, 64'd6);
        check("rr_data", 64'(rd3), 64'h300);
        v3 = 3'b000;
        step();
        check("rr_idle_stall", 64'(st3), 64'd0);
        check("rr_idle_valid", 64'(ov3), 64'd0);

        // Counter wrap from all-ones
        force u2.or_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release u2.or_instret;
        #1 check("wrap_preload", ir2, 64'hFFFF_FFFF_FFFF_FFFF);
        v2 = 2'b01;
        step();
        check("wrap_instret", ir2, 64'd0);
        check("wrap_valid", 64'(ov2), 64'd1);
        v2 = 2'b00;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
